imem_fetch_unit: RTL and testbench

//  Parametrised, run-time programmable instruction memory for the ARM-subset core.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_fetch_if.sv | 33 +++
 rtl/imem_ram.sv | 33 +++
 rtl/imem_fetch_unit.sv | 133 +++++++++++++
 tb/tb_imem_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory fetch unit.
//   imem_state_t : CLEAR (post-reset RAM wipe), RUN (fetch service), PROG (program load)
//   DEF_NOP_WORD : default clear value, also returned on a faulted fetch
//   is_aligned   : true when a byte address is word aligned (low two bits zero)
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    PROG  = 2'd2
  } imem_state_t;

  localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/imem_fetch_if.sv
// Bus bundle between the core (master) and the instruction memory (slave).
//   fetch_req/fetch_addr/fetch_gnt          : fetch request channel
//   instr_valid/instr_ready/instr/instr_fault : fetch result channel
//   prog_en/prog_we/prog_addr/prog_data/prog_err : program-load port
//   busy                                    : memory not serving fetches
interface imem_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic              instr_fault;
  logic              prog_en;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_err;
  logic              busy;

  modport master (
    output fetch_req, fetch_addr, instr_ready, prog_en, prog_we, prog_addr, prog_data,
    input  fetch_gnt, instr_valid, instr, instr_fault, prog_err, busy
  );

  modport slave (
    input  fetch_req, fetch_addr, instr_ready, prog_en, prog_we, prog_addr, prog_data,
    output fetch_gnt, instr_valid, instr, instr_fault, prog_err, busy
  );
endinterface

// File: rtl/imem_ram.sv
// Single-port synchronous RAM holding the instruction words.
//   clk   : rising-edge clock
//   we    : write wdata at idx (takes precedence over re)
//   re    : read idx into rdata; rdata holds its value when re is low
//   idx   : word index
//   wdata : write data
//   rdata : registered read data
module imem_ram
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Run-time programmable instruction memory with a 1-cycle fetch handshake.
// After reset the RAM is wiped to NOP_WORD, one word per cycle; the core can
// then fetch (result one cycle after grant, held until consumed) or hold the
// memory in program-load mode to write new contents.
//   clk, reset : clock and synchronous active-high reset
//   bus        : imem_fetch_if slave side (fetch, result, program-load, busy)
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 2 ** (ADDR_W - 2),
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEF_NOP_WORD)
) (
  input  logic         clk,
  input  logic         reset,
  imem_fetch_if.slave  bus
);

  localparam int IDX_W = ADDR_W - 2;

  imem_state_t       state, state_nxt;
  logic [IDX_W-1:0]  clr_idx;
  logic              clr_last;
  logic [IDX_W-1:0]  fetch_idx, prog_idx;
  logic              fetch_bad, prog_bad;
  logic              drained;
  logic              gnt;
  logic              ram_we, ram_re;
  logic [IDX_W-1:0]  ram_idx;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              prog_err_d;
  logic              vld_p1, fault_p1, prog_err_p1;

  // No wrap-around: an index past the populated words is a fault, not an alias.
  function automatic logic idx_oob(input logic [IDX_W-1:0] idx);
    return 32'(idx) >= 32'(DEPTH);
  endfunction

  assign fetch_idx = bus.fetch_addr[ADDR_W-1:2];
  assign prog_idx  = bus.prog_addr[ADDR_W-1:2];
  assign fetch_bad = !is_aligned(bus.fetch_addr[1:0]) || idx_oob(fetch_idx);
  assign prog_bad  = !is_aligned(bus.prog_addr[1:0]) || idx_oob(prog_idx);
  assign clr_last  = 32'(clr_idx) == 32'(DEPTH - 1);
  // The hold register is free when empty or being emptied this cycle.
  assign drained   = !vld_p1 || bus.instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR;
      clr_idx     <= '0;
      vld_p1      <= 1'b0;
      fault_p1    <= 1'b0;
      prog_err_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        clr_idx <= clr_idx + IDX_W'(1);
      end
      if (gnt) begin
        vld_p1   <= 1'b1;
        fault_p1 <= fetch_bad;
      end else if (bus.instr_ready) begin
        vld_p1 <= 1'b0;
      end
      prog_err_p1 <= prog_err_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_last) state_nxt = RUN;
      RUN:     if (bus.prog_en && drained) state_nxt = PROG;
      PROG:    if (!bus.prog_en) state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // The single RAM port is shared: CLEAR/PROG write, RUN reads.
  always_comb begin
    gnt        = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_idx    = fetch_idx;
    ram_wdata  = NOP_WORD;
    prog_err_d = 1'b0;
    case (state)
      CLEAR: begin
        ram_we  = 1'b1;
        ram_idx = clr_idx;
      end
      RUN: begin
        gnt    = bus.fetch_req && !bus.prog_en && drained;
        ram_re = gnt && !fetch_bad;
      end
      PROG: begin
        if (bus.prog_en && bus.prog_we) begin
          if (prog_bad) begin
            prog_err_d = 1'b1;
          end else begin
            ram_we    = 1'b1;
            ram_idx   = prog_idx;
            ram_wdata = bus.prog_data;
          end
        end
      end
      default: ;
    endcase
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // ---- stage p1: result hold (RAM rdata is only refreshed on a granted read) ----
  assign bus.fetch_gnt   = gnt;
  assign bus.instr_valid = vld_p1;
  assign bus.instr_fault = fault_p1;
  assign bus.instr       = (vld_p1 && !fault_p1) ? ram_rdata : NOP_WORD;
  assign bus.prog_err    = prog_err_p1;
  assign bus.busy        = state != RUN;

endmodule

// File: tb/tb_imem_fetch_unit.sv
module tb_imem_fetch_unit;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  imem_fetch_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {M_CLEAR, M_RUN, M_PROG} mmode_t;
  bit          model_on = 1'b0;
  mmode_t      m_mode = M_CLEAR;
  int          m_clr_left;
  bit          m_hv, m_hf, m_perr;
  logic [31:0] m_hi;
  logic [31:0] m_mem [DEPTH];
  bit          m_g, m_dr;

  function automatic bit bad_addr(logic [7:0] a);
    return (a[1:0] != 2'b00) || (int'(a >> 2) >= DEPTH);
  endfunction

  function automatic bit exp_gnt();
    return (m_mode == M_RUN) && bus.fetch_req && !bus.prog_en && (!m_hv || bus.instr_ready);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      model_on   = 1'b1;
      m_mode     = M_CLEAR;
      m_clr_left = DEPTH;
      m_hv       = 1'b0;
      m_hf       = 1'b0;
      m_hi       = 32'h0;
      m_perr     = 1'b0;
      foreach (m_mem[i]) m_mem[i] = 32'h0;
    end else if (model_on) begin
      m_g    = exp_gnt();
      m_dr   = !m_hv || bus.instr_ready;
      m_perr = 1'b0;
      case (m_mode)
        M_CLEAR: begin
          m_clr_left--;
          if (m_clr_left == 0) m_mode = M_RUN;
        end
        M_RUN: begin
          if (m_g) begin
            m_hv = 1'b1;
            m_hf = bad_addr(bus.fetch_addr);
            m_hi = m_hf ? 32'h0 : m_mem[int'(bus.fetch_addr >> 2)];
          end else if (bus.instr_ready) begin
            m_hv = 1'b0;
          end
          if (bus.prog_en && m_dr) m_mode = M_PROG;
        end
        default: begin
          if (!bus.prog_en) m_mode = M_RUN;
          else if (bus.prog_we) begin
            if (bad_addr(bus.prog_addr)) m_perr = 1'b1;
            else m_mem[int'(bus.prog_addr >> 2)] = bus.prog_data;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("m_busy", bus.busy, m_mode != M_RUN);
      chk("m_fetch_gnt", bus.fetch_gnt, exp_gnt());
      chk("m_instr_valid", bus.instr_valid, m_hv);
      chk("m_prog_err", bus.prog_err, m_perr);
      if (m_hv) begin
        chk("m_instr", bus.instr, m_hi);
        chk("m_instr_fault", bus.instr_fault, m_hf);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fetch_req   = 1'b0;
    bus.fetch_addr  = '0;
    bus.instr_ready = 1'b0;
    bus.prog_en     = 1'b0;
    bus.prog_we     = 1'b0;
    bus.prog_addr   = '0;
    bus.prog_data   = '0;
  endtask

  // Called right after reset is released; counts cycles with busy high.
  task automatic count_busy(string name);
    int n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      step();
    end
    chk(name, n, 64);
  endtask

  bit pmode = 1'b0;

  initial begin
    idle();
    // 1: reset state, clear length, first fetch
    reset = 1'b1;
    bus.fetch_req = 1'b1;
    step();
    chk("rst_busy", bus.busy, 1);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_fault", bus.instr_fault, 0);
    chk("rst_prog_err", bus.prog_err, 0);
    chk("rst_gnt", bus.fetch_gnt, 0);
    bus.fetch_req = 1'b0;
    reset = 1'b0;
    count_busy("t1_busy_cycles");
    bus.fetch_req = 1'b1; bus.fetch_addr = 8'h00; bus.instr_ready = 1'b1;
    #1 chk("t1_gnt", bus.fetch_gnt, 1);
    step();
    chk("t1_valid", bus.instr_valid, 1);
    chk("t1_instr", bus.instr, 32'h0);
    chk("t1_fault", bus.instr_fault, 0);
    bus.fetch_req = 1'b0;

    // 2: program three words, back-to-back fetch
    bus.prog_en = 1'b1;
    step();
    chk("t2_prog_busy", bus.busy, 1);
    chk("t2_prog_valid", bus.instr_valid, 0);
    bus.prog_we = 1'b1;
    bus.prog_addr = 8'h00; bus.prog_data = 32'hE04F000F; step();
    bus.prog_addr = 8'h04; bus.prog_data = 32'hE2801002; step();
    bus.prog_addr = 8'h30; bus.prog_data = 32'hE0845004; step();
    bus.prog_we = 1'b0; bus.prog_en = 1'b0;
    step();
    chk("t2_run_busy", bus.busy, 0);
    bus.fetch_req = 1'b1; bus.fetch_addr = 8'h00; step();
    chk("t2_v0", bus.instr_valid, 1); chk("t2_i0", bus.instr, 32'hE04F000F);
    bus.fetch_addr = 8'h04; step();
    chk("t2_v1", bus.instr_valid, 1); chk("t2_i1", bus.instr, 32'hE2801002);
    bus.fetch_addr = 8'h30; step();
    chk("t2_v2", bus.instr_valid, 1); chk("t2_i2", bus.instr, 32'hE0845004);
    bus.fetch_req = 1'b0; step();
    chk("t2_drain", bus.instr_valid, 0);

    // 3: stall holds result, release grants same cycle
    bus.fetch_req = 1'b1; bus.fetch_addr = 8'h04; step();
    chk("t3_first", bus.instr, 32'hE2801002);
    bus.instr_ready = 1'b0; bus.fetch_addr = 8'h00;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t3_stall_gnt", bus.fetch_gnt, 0);
      step();
      chk("t3_hold_valid", bus.instr_valid, 1);
      chk("t3_hold_instr", bus.instr, 32'hE2801002);
    end
    bus.instr_ready = 1'b1;
    #1 chk("t3_release_gnt", bus.fetch_gnt, 1);
    step();
    chk("t3_next_instr", bus.instr, 32'hE04F000F);
    bus.fetch_req = 1'b0; step();

    // 4: misaligned fetch faults; bad program write pulses prog_err
    bus.fetch_req = 1'b1; bus.fetch_addr = 8'h06; step();
    chk("t4_valid", bus.instr_valid, 1);
    chk("t4_fault", bus.instr_fault, 1);
    chk("t4_instr", bus.instr, 32'h0);
    bus.fetch_req = 1'b0; step();
    bus.prog_en = 1'b1; step();
    bus.prog_we = 1'b1; bus.prog_addr = 8'h0A; bus.prog_data = 32'hDEADBEEF; step();
    chk("t4_prog_err", bus.prog_err, 1);
    bus.prog_we = 1'b0; step();
    chk("t4_prog_err_pulse", bus.prog_err, 0);
    bus.prog_en = 1'b0; step();
    bus.fetch_req = 1'b1; bus.fetch_addr = 8'h08; step();
    chk("t4_mem2", bus.instr, 32'h0);
    chk("t4_mem2_fault", bus.instr_fault, 0);
    bus.fetch_req = 1'b0; step();

    // 5: prog_en waits for the held result to drain
    bus.fetch_req = 1'b1; bus.fetch_addr = 8'h00; step();
    bus.instr_ready = 1'b0; bus.prog_en = 1'b1;
    #1 chk("t5_gnt_stall", bus.fetch_gnt, 0);
    step();
    chk("t5_still_run", bus.busy, 0); chk("t5_still_valid", bus.instr_valid, 1);
    step();
    chk("t5_still_run2", bus.busy, 0);
    bus.instr_ready = 1'b1;
    #1 chk("t5_gnt_prog_prio", bus.fetch_gnt, 0);
    step();
    chk("t5_prog", bus.busy, 1); chk("t5_drained", bus.instr_valid, 0);
    bus.prog_en = 1'b0; bus.fetch_req = 1'b0; step();
    chk("t5_back_run", bus.busy, 0);

    // 6: reset mid-clear, in PROG, mid-stall
    reset = 1'b1; step(); reset = 1'b0;
    repeat (20) step();
    reset = 1'b1; step();
    chk("t6a_busy", bus.busy, 1); chk("t6a_valid", bus.instr_valid, 0);
    reset = 1'b0;
    count_busy("t6a_busy_cycles");
    bus.prog_en = 1'b1; step();
    chk("t6b_in_prog", bus.busy, 1);
    bus.prog_we = 1'b1; bus.prog_addr = 8'h10; bus.prog_data = 32'h12345678; step();
    bus.prog_we = 1'b0; bus.prog_en = 1'b0; reset = 1'b1; step();
    reset = 1'b0;
    count_busy("t6b_busy_cycles");
    bus.fetch_req = 1'b1; bus.fetch_addr = 8'h00; bus.instr_ready = 1'b1; step();
    bus.fetch_req = 1'b0; bus.instr_ready = 1'b0; step();
    chk("t6c_stalled", bus.instr_valid, 1);
    reset = 1'b1; step();
    chk("t6c_dropped", bus.instr_valid, 0);
    reset = 1'b0;
    count_busy("t6c_busy_cycles");
    bus.fetch_req = 1'b1; bus.instr_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.fetch_addr = 8'(i * 4);
      step();
      chk("t6_readback_valid", bus.instr_valid, 1);
      chk("t6_readback", bus.instr, 32'h0);
    end
    bus.fetch_req = 1'b0; step();

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 24) == 0) pmode = !pmode;
      bus.prog_en     = pmode;
      bus.fetch_req   = ($urandom_range(0, 2) != 0);
      bus.fetch_addr  = ($urandom_range(0, 5) == 0) ? 8'($urandom) :
                        ($urandom_range(0, 1) == 0) ? {2'b00, 4'($urandom), 2'b00} :
                                                      {6'($urandom), 2'b00};
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      bus.prog_we     = 1'($urandom_range(0, 1));
      bus.prog_addr   = ($urandom_range(0, 5) == 0) ? 8'($urandom) : {2'b00, 4'($urandom), 2'b00};
      bus.prog_data   = $urandom;
      step();
    end
    reset = 1'b0;
    idle();
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
